// File: rtl/serial_frame_tx_if.sv
// Handshake bundle for the serial frame transmitter.
// The producer drives D_IN and LOAD; the transmitter drives the line and its status.
interface serial_frame_tx_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] D_IN;
    logic              LOAD;
    logic              READY;
    logic              TX;
    logic              BUSY;
    logic              DONE;

    modport master (
        output D_IN,
        output LOAD,
        input  READY,
        input  TX,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  D_IN,
        input  LOAD,
        output READY,
        output TX,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-in / serial-out frame transmitter, LSB first.
// Frame: start (0), data bits, optional even parity, stop (1); every output is registered.
module serial_frame_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic             C,
    input  logic             RE,
    serial_frame_tx_if.slave bus
);
    localparam int unsigned     CycW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned     BitW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            r_state, w_state_d;
    logic [CycW-1:0]   r_cyc, w_cyc_d;
    logic [BitW-1:0]   r_bit, w_bit_d;
    logic [DATA_W-1:0] r_shreg, w_shreg_d;
    logic              r_parity, w_parity_d;
    logic              r_tx, w_tx_d;
    logic              r_ready, w_ready_d;
    logic              r_done, w_done_d;
    logic              w_accept;
    logic              w_term;

    assign w_accept = bus.LOAD & r_ready;
    assign w_term   = (r_cyc == CycLast);

    always_ff @(posedge C or posedge RE) begin
        if (RE) begin
            r_state  <= StIdle;
            r_cyc    <= '0;
            r_bit    <= '0;
            r_shreg  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cyc    <= w_cyc_d;
            r_bit    <= w_bit_d;
            r_shreg  <= w_shreg_d;
            r_parity <= w_parity_d;
            r_tx     <= w_tx_d;
            r_ready  <= w_ready_d;
            r_done   <= w_done_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_cyc_d    = r_cyc;
        w_bit_d    = r_bit;
        w_shreg_d  = r_shreg;
        w_parity_d = r_parity;
        // Cycle counter free-runs through every non-idle state, restarting at terminal count.
        if (r_state != StIdle) begin
            w_cyc_d = w_term ? '0 : r_cyc + 1'b1;
        end
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d  = StStart;
                    w_cyc_d    = '0;
                    w_bit_d    = '0;
                    w_shreg_d  = bus.D_IN;
                    w_parity_d = ^bus.D_IN;
                end
            end
            StStart: begin
                if (w_term) w_state_d = StData;
            end
            StData: begin
                if (w_term) begin
                    w_shreg_d = r_shreg >> 1;
                    if (r_bit == BitLast) begin
                        w_bit_d   = '0;
                        w_state_d = PARITY_EN ? StParity : StStop;
                    end else begin
                        w_bit_d = r_bit + 1'b1;
                    end
                end
            end
            StParity: begin
                if (w_term) w_state_d = StStop;
            end
            StStop: begin
                if (w_term) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registered line is aligned with it.
    always_comb begin
        w_tx_d    = 1'b1;
        w_ready_d = 1'b0;
        unique case (w_state_d)
            StIdle:   w_ready_d = 1'b1;
            StStart:  w_tx_d    = 1'b0;
            StData:   w_tx_d    = w_shreg_d[0];
            StParity: w_tx_d    = w_parity_d;
            default:  w_tx_d    = 1'b1;
        endcase
        w_done_d = (r_state == StStop) && w_term;
    end

    assign bus.TX    = r_tx;
    assign bus.READY = r_ready;
    assign bus.BUSY  = ~r_ready;
    assign bus.DONE  = r_done;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: random and directed words checked cycle by cycle
// against a frame model built from the line-level description of a frame.
module tb_serial_frame_tx;
    localparam int unsigned FA = (2 + 8 + 1) * 4;
    localparam int unsigned FB = (2 + 8) * 1;

    typedef bit bits_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt_a = 0;

    serial_frame_tx_if #(.DATA_W(8)) bus_a ();
    serial_frame_tx_if #(.DATA_W(8)) bus_b ();

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (
        .C   (clk),
        .RE  (rst),
        .bus (bus_a)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut_b (
        .C   (clk),
        .RE  (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus_a.DONE === 1'b1) done_cnt_a++;

    // Line level for every clock of a frame, starting with the cycle after the accept edge.
    function automatic bits_q_t frame_bits(input logic [7:0] w, input int cpb, input bit par_en);
        bits_q_t q;
        bit      lvl[$];
        lvl.push_back(1'b0);
        for (int b = 0; b < 8; b++) lvl.push_back(w[b]);
        if (par_en) lvl.push_back(($countones(w) % 2) == 1);
        lvl.push_back(1'b1);
        foreach (lvl[k]) for (int c = 0; c < cpb; c++) q.push_back(lvl[k]);
        return q;
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        bus_a.LOAD = 1'b0;
        bus_a.D_IN = '0;
        bus_b.LOAD = 1'b0;
        bus_b.D_IN = '0;
        #1 rst = 1'b1;
        #1;
        obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
        n_checks++;
        if (obs !== 4'b1100) $display("FAIL reset_async: {tx,ready,busy,done}=%b expected 1100", obs);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        obs = {bus_b.TX, bus_b.READY, bus_b.BUSY, bus_b.DONE};
        n_checks++;
        if (obs !== 4'b1100) $display("FAIL reset_b: {tx,ready,busy,done}=%b expected 1100", obs);
        else n_pass++;
    endtask

    task automatic test_frame(input logic [7:0] w, input string tag);
        bits_q_t    exp_q = frame_bits(w, 4, 1'b1);
        logic [3:0] obs;
        obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
        n_checks++;
        if (obs !== 4'b1100) $display("FAIL %s idle: {tx,ready,busy,done}=%b expected 1100", tag, obs);
        else n_pass++;
        bus_a.D_IN = w;
        bus_a.LOAD = 1'b1;
        @(posedge clk);
        for (int i = 0; i < FA; i++) begin
            @(negedge clk);
            bus_a.LOAD = 1'b0;
            obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
            n_checks++;
            if (obs !== {exp_q[i], 3'b010})
                $display("FAIL %s cycle %0d: {tx,ready,busy,done}=%b expected %b",
                         tag, i, obs, {exp_q[i], 3'b010});
            else n_pass++;
        end
        @(negedge clk);
        obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
        n_checks++;
        if (obs !== 4'b1101) $display("FAIL %s done: {tx,ready,busy,done}=%b expected 1101", tag, obs);
        else n_pass++;
        @(negedge clk);
        obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
        n_checks++;
        if (obs !== 4'b1100) $display("FAIL %s done_clear: {tx,ready,busy,done}=%b expected 1100", tag, obs);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) test_frame(8'($urandom), "random");
    endtask

    // first_w is sent; second_w appears on D_IN (with LOAD held) from cycle chg_at onward.
    task automatic test_pair(input logic [7:0] first_w, input logic [7:0] second_w,
                             input int chg_at, input string tag);
        bits_q_t    exp1 = frame_bits(first_w, 4, 1'b1);
        bits_q_t    exp2 = frame_bits(second_w, 4, 1'b1);
        logic [3:0] obs;
        int         done0 = done_cnt_a;
        bus_a.D_IN = first_w;
        bus_a.LOAD = 1'b1;
        @(posedge clk);
        for (int i = 0; i < FA; i++) begin
            @(negedge clk);
            if (i >= chg_at) bus_a.D_IN = second_w;
            obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
            n_checks++;
            if (obs !== {exp1[i], 3'b010})
                $display("FAIL %s first cycle %0d: {tx,ready,busy,done}=%b expected %b",
                         tag, i, obs, {exp1[i], 3'b010});
            else n_pass++;
        end
        @(negedge clk);
        bus_a.D_IN = second_w;
        obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
        n_checks++;
        if (obs !== 4'b1101) $display("FAIL %s first_done: {tx,ready,busy,done}=%b expected 1101", tag, obs);
        else n_pass++;
        for (int i = 0; i < FA; i++) begin
            @(negedge clk);
            bus_a.LOAD = 1'b0;
            obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
            n_checks++;
            if (obs !== {exp2[i], 3'b010})
                $display("FAIL %s second cycle %0d: {tx,ready,busy,done}=%b expected %b",
                         tag, i, obs, {exp2[i], 3'b010});
            else n_pass++;
        end
        @(negedge clk);
        obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
        n_checks++;
        if (obs !== 4'b1101) $display("FAIL %s second_done: {tx,ready,busy,done}=%b expected 1101", tag, obs);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done_cnt_a - done0 !== 2)
            $display("FAIL %s done_pulses: counted %0d expected 2", tag, done_cnt_a - done0);
        else n_pass++;
    endtask

    task automatic test_ignore_load();
        test_pair(8'h3C, 8'hFF, 5, "ignore_load");
    endtask

    task automatic test_back_to_back();
        test_pair(8'h12, 8'h34, FA, "back_to_back");
    endtask

    task automatic test_reset_abort();
        bits_q_t    exp_q = frame_bits(8'hC3, 4, 1'b1);
        logic [3:0] obs;
        int         bad = 0;
        int         done0;
        bus_a.D_IN = 8'hC3;
        bus_a.LOAD = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_a.LOAD = 1'b0;
            obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
            n_checks++;
            if (obs !== {exp_q[i], 3'b010})
                $display("FAIL abort_pre cycle %0d: {tx,ready,busy,done}=%b expected %b",
                         i, obs, {exp_q[i], 3'b010});
            else n_pass++;
        end
        done0 = done_cnt_a;
        rst = 1'b1;
        #1;
        obs = {bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE};
        n_checks++;
        if (obs !== 4'b1100) $display("FAIL abort_now: {tx,ready,busy,done}=%b expected 1100", obs);
        else n_pass++;
        #1 rst = 1'b0;
        for (int i = 0; i < FA + 4; i++) begin
            @(negedge clk);
            if ({bus_a.TX, bus_a.READY, bus_a.BUSY, bus_a.DONE} !== 4'b1100) bad++;
        end
        n_checks++;
        if (bad != 0 || done_cnt_a != done0)
            $display("FAIL abort_quiet: bad cycles %0d, done pulses %0d, expected 0 and 0",
                     bad, done_cnt_a - done0);
        else n_pass++;
        test_frame(8'h5A, "after_abort");
    endtask

    task automatic test_fast(input logic [7:0] w);
        bits_q_t    exp_q = frame_bits(w, 1, 1'b0);
        logic [3:0] obs;
        bus_b.D_IN = w;
        bus_b.LOAD = 1'b1;
        @(posedge clk);
        for (int i = 0; i < FB; i++) begin
            @(negedge clk);
            bus_b.LOAD = 1'b0;
            obs = {bus_b.TX, bus_b.READY, bus_b.BUSY, bus_b.DONE};
            n_checks++;
            if (obs !== {exp_q[i], 3'b010})
                $display("FAIL fast %h cycle %0d: {tx,ready,busy,done}=%b expected %b",
                         w, i, obs, {exp_q[i], 3'b010});
            else n_pass++;
        end
        @(negedge clk);
        obs = {bus_b.TX, bus_b.READY, bus_b.BUSY, bus_b.DONE};
        n_checks++;
        if (obs !== 4'b1101) $display("FAIL fast %h done: {tx,ready,busy,done}=%b expected 1101", w, obs);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, "frame_a5");
        test_frame(8'h07, "frame_07");
        test_random();
        test_ignore_load();
        test_back_to_back();
        test_reset_abort();
        test_fast(8'h01);
        test_fast(8'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
